// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared types and constants for the seven-segment shift
//             sequencer: FSM state encoding, pattern width, digit width and
//             the one-digit left-rotation helper used for scrolling.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int SEG_BITS    = 64;
  localparam int SEG_DIGIT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } seg_state_e;

  // Leftmost digit moves to the rightmost position.
  function automatic logic [SEG_BITS-1:0] seg_rotate(input logic [SEG_BITS-1:0] p);
    return {p[SEG_BITS-SEG_DIGIT_W-1:0], p[SEG_BITS-1 -: SEG_DIGIT_W]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : seg_tick_gen
//  Purpose  : Scroll-rate timer. Counts 0..SCROLL_TICKS-1 while enabled and
//             flags the wrap cycle; held at zero while disabled.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset
//             en   - count enable (level)
//             tick - high during the cycle in which the counter wraps
//  Revision : 1.0 - initial release
// ============================================================================
module seg_tick_gen #(
  parameter int SCROLL_TICKS = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W    = $clog2(SCROLL_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_shift_ctrl
//  Purpose  : Serialises a 64-bit seven-segment pattern into an external
//             shift-register chain (MSB first), latches it, and rotates the
//             held pattern one digit per scroll tick when scrolling is on.
//  Ports    : clk       - clock
//             rst       - synchronous active-high reset
//             data_in   - new pattern, [63:56] is the leftmost digit
//             load      - one-cycle write strobe for data_in
//             scroll_en - enables periodic one-digit rotation
//             busy      - frame shifting/latching in progress
//             done      - one-cycle pulse after a frame is latched
//             seg_clk   - chain shift clock
//             seg_dout  - chain serial data
//             seg_latch - chain storage latch pulse
//  Revision : 1.0 - initial release
// ============================================================================
module seg_shift_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int SCROLL_TICKS = 25_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SEG_BITS-1:0] data_in,
  input  logic                load,
  input  logic                scroll_en,
  output logic                busy,
  output logic                done,
  output logic                seg_clk,
  output logic                seg_dout,
  output logic                seg_latch
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  seg_state_e          state_q, state_d;
  logic [SEG_BITS-1:0] pat_q, pat_d;
  logic [SEG_BITS-1:0] sreg_q, sreg_d;
  logic [SEG_BITS-1:0] pend_d_q, pend_d_d;
  logic                pend_v_q, pend_v_d;
  logic                scroll_pend_q, scroll_pend_d;
  logic [5:0]          bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0]    divcnt_q, divcnt_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                seg_clk_q, seg_clk_d;
  logic                seg_dout_q, seg_dout_d;
  logic                seg_latch_q, seg_latch_d;

  logic                w_tick;
  logic                w_phase_end;

  seg_tick_gen #(
    .SCROLL_TICKS (SCROLL_TICKS)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (scroll_en),
    .tick (w_tick)
  );

  assign w_phase_end = (divcnt_q == DIV_LAST);

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    sreg_d        = sreg_q;
    pend_d_d      = pend_d_q;
    pend_v_d      = pend_v_q;
    scroll_pend_d = scroll_pend_q;
    bitcnt_d      = bitcnt_q;
    divcnt_d      = divcnt_q;

    // A tick while a step is already pending is simply absorbed.
    if (!scroll_en) begin
      scroll_pend_d = 1'b0;
    end else if (w_tick) begin
      scroll_pend_d = 1'b1;
    end

    // Loads that cannot start a frame now are buffered; latest one wins.
    if (load && (state_q != IDLE)) begin
      pend_d_d = data_in;
      pend_v_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (load) begin
          // A direct load supersedes any older buffered pattern.
          pat_d    = data_in;
          sreg_d   = data_in;
          pend_v_d = 1'b0;
          state_d  = LOW;
        end else if (pend_v_q) begin
          pat_d    = pend_d_q;
          sreg_d   = pend_d_q;
          pend_v_d = 1'b0;
          state_d  = LOW;
        end else if (scroll_pend_q && scroll_en) begin
          pat_d         = seg_rotate(pat_q);
          sreg_d        = seg_rotate(pat_q);
          scroll_pend_d = w_tick;
          state_d       = LOW;
        end
        if (state_d == LOW) begin
          bitcnt_d = '0;
          divcnt_d = '0;
        end
      end

      LOW: begin
        if (w_phase_end) begin
          divcnt_d = '0;
          state_d  = HIGH;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end

      HIGH: begin
        if (w_phase_end) begin
          divcnt_d = '0;
          sreg_d   = {sreg_q[SEG_BITS-2:0], 1'b0};
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = (bitcnt_q == 6'd63) ? LATCH : LOW;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end

      LATCH: begin
        if (w_phase_end) begin
          divcnt_d = '0;
          state_d  = DONE;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so every pin is a flop.
    busy_d      = (state_d == LOW) || (state_d == HIGH) || (state_d == LATCH);
    done_d      = (state_d == DONE);
    seg_clk_d   = (state_d == HIGH);
    seg_latch_d = (state_d == LATCH);
    if (state_d == LOW) begin
      seg_dout_d = sreg_d[SEG_BITS-1];
    end else if (state_d == HIGH) begin
      seg_dout_d = seg_dout_q;
    end else begin
      seg_dout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      sreg_q        <= '0;
      pend_d_q      <= '0;
      pend_v_q      <= 1'b0;
      scroll_pend_q <= 1'b0;
      bitcnt_q      <= '0;
      divcnt_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      seg_clk_q     <= 1'b0;
      seg_dout_q    <= 1'b0;
      seg_latch_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      sreg_q        <= sreg_d;
      pend_d_q      <= pend_d_d;
      pend_v_q      <= pend_v_d;
      scroll_pend_q <= scroll_pend_d;
      bitcnt_q      <= bitcnt_d;
      divcnt_q      <= divcnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      seg_clk_q     <= seg_clk_d;
      seg_dout_q    <= seg_dout_d;
      seg_latch_q   <= seg_latch_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign seg_clk   = seg_clk_q;
  assign seg_dout  = seg_dout_q;
  assign seg_latch = seg_latch_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_shift_ctrl
//  Purpose  : Scoreboard bench for seg_shift_ctrl (CLK_DIV=1,
//             SCROLL_TICKS=300). Stimulus queues the frames it expects; a
//             monitor rebuilds each frame from seg_clk/seg_dout and checks it
//             together with busy/latch lengths when done pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        scroll_en = 1'b0;
  logic [63:0] data_in = '0;
  logic        busy, done, seg_clk, seg_dout, seg_latch;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  seg_shift_ctrl #(
    .CLK_DIV      (1),
    .SCROLL_TICKS (300)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .load      (load),
    .scroll_en (scroll_en),
    .busy      (busy),
    .done      (done),
    .seg_clk   (seg_clk),
    .seg_dout  (seg_dout),
    .seg_latch (seg_latch)
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [63:0] mon_sh    = '0;
  int          mon_bits  = 0;
  int          mon_busy  = 0;
  int          mon_latch = 0;
  logic        prev_clk  = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (seg_clk && !prev_clk) begin
      mon_sh = {mon_sh[62:0], seg_dout};
      mon_bits++;
    end
    if (busy)      mon_busy++;
    if (seg_latch) mon_latch++;
    if (done) begin
      check("done_single", 64'(prev_done), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL frame_unexpected: got %h expected none", mon_sh);
      end else begin
        check("frame_data", mon_sh, exp_q.pop_front());
      end
      check("frame_bits", 64'(mon_bits), 64'd64);
      check("busy_len", 64'(mon_busy), 64'd129);
      check("latch_len", 64'(mon_latch), 64'd1);
      done_cnt++;
    end
    if (!busy) begin
      mon_sh    = '0;
      mon_bits  = 0;
      mon_busy  = 0;
      mon_latch = 0;
    end
    prev_clk  = seg_clk;
    prev_done = done;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_load(input logic [63:0] d);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("frame_arrival", 64'(done_cnt), 64'(target));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_segclk"}, 64'(seg_clk), 64'd0);
    check({name, "_dout"}, 64'(seg_dout), 64'd0);
    check({name, "_latch"}, 64'(seg_latch), 64'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame, first-bit latency
    base = done_cnt;
    exp_q.push_back(64'hA5C3_0000_FFFF_0123);
    drive_load(64'hA5C3_0000_FFFF_0123);
    check("start_busy", 64'(busy), 64'd1);
    check("start_dout", 64'(seg_dout), 64'd1);
    wait_done(base + 1);
    repeat (5) @(negedge clk);

    // Pending buffer: latest load wins, frames back to back
    base = done_cnt;
    exp_q.push_back(64'h1);
    drive_load(64'h1);
    repeat (9) @(negedge clk);
    drive_load(64'h2);
    repeat (9) @(negedge clk);
    exp_q.push_back(64'h3);
    drive_load(64'h3);
    wait_done(base + 2);
    repeat (200) @(negedge clk);
    check("pend_frames", 64'(done_cnt), 64'(base + 2));
    check("pend_queue", 64'(exp_q.size()), 64'd0);

    // Scrolling rotates by one digit per tick
    base = done_cnt;
    exp_q.push_back(64'h0102030405060708);
    drive_load(64'h0102030405060708);
    wait_done(base + 1);
    scroll_en = 1'b1;
    exp_q.push_back(64'h0203040506070801);
    wait_done(base + 2);
    exp_q.push_back(64'h0304050607080102);
    wait_done(base + 3);
    scroll_en = 1'b0;
    repeat (5) @(negedge clk);

    // Load on the wrap cycle: load first, then rotation of the new pattern
    base = done_cnt;
    scroll_en = 1'b1;
    repeat (299) @(negedge clk);
    exp_q.push_back(64'h0000_0000_0000_00FF);
    exp_q.push_back(64'h0000_0000_0000_FF00);
    drive_load(64'hFF);
    wait_done(base + 2);
    scroll_en = 1'b0;
    repeat (5) @(negedge clk);

    // Reset mid-frame abandons the frame
    base = done_cnt;
    drive_load(64'h1234_5678_9ABC_DEF0);
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst_mid");
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("no_frame_after_rst", 64'(done_cnt), 64'(base));
    exp_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
    drive_load(64'hDEAD_BEEF_0BAD_F00D);
    check("post_rst_busy", 64'(busy), 64'd1);
    check("post_rst_dout", 64'(seg_dout), 64'd1);
    wait_done(base + 1);
    repeat (5) @(negedge clk);

    // Dropping scroll_en just before wrap restarts the timer
    base = done_cnt;
    scroll_en = 1'b1;
    repeat (298) @(negedge clk);
    scroll_en = 1'b0;
    @(negedge clk);
    scroll_en = 1'b1;
    repeat (250) @(negedge clk);
    check("no_rotation", 64'(done_cnt), 64'(base));
    exp_q.push_back(64'hADBE_EF0B_ADF0_0DDE);
    repeat (50) @(negedge clk);
    check("tick_not_early", 64'(busy), 64'd0);
    @(negedge clk);
    check("tick_on_time", 64'(busy), 64'd1);
    wait_done(base + 1);
    scroll_en = 1'b0;
    repeat (5) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
